// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, pending-redirect kinds and
// the fixed fetch addresses.
package cpu_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   typedef enum logic {
      PEND_EXC  = 1'b0,
      PEND_ERET = 1'b1
   } pend_kind_e;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/npc_target.sv
// Decode-stage target selection: sequential, taken branch, j/jal and jr/jalr.
// Purely combinational; redirect priority lives in npc_unit.
module npc_target
   import cpu_pkg::*;
(
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  npc_sel_e    npc_sel,
   input  logic        br_cond,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_val,
   output logic [31:0] target
);

   logic [31:0] seq_target;
   logic [31:0] br_target;
   logic [31:0] j_target;

   assign seq_target = pc_f + 32'd4;
   // Branch offset is relative to the delay slot, i.e. pc_d + 4.
   assign br_target  = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign j_target   = {pc_d[31:28], imm26, 2'b00};

   always_comb begin
      target = seq_target;
      case (npc_sel)
         NPC_BR:  target = br_cond ? br_target : seq_target;
         NPC_J:   target = j_target;
         NPC_JR:  target = rs_val;
         default: target = seq_target;
      endcase
   end

endmodule

// File: rtl/npc_unit.sv
// Next-PC generator: decode target, exc/eret priority, a one-entry buffer for
// redirects raised while fetch is stalled, delay-slot and fetch-fault flags.
module npc_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] IMEM_LO = 32'h0000_3000,
   parameter logic [31:0] IMEM_HI = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  logic [1:0]  npc_sel,
   input  logic        br_cond,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_val,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output logic        f_bd,
   output logic        if_adel,
   output logic        redirect_pending
);

   logic        pend_valid;
   pend_kind_e  pend_kind;
   logic [31:0] pend_target;
   logic [31:0] dec_target;
   logic        redirect_sel;

   npc_target u_target (
      .pc_f    (pc_f),
      .pc_d    (pc_d),
      .npc_sel (npc_sel_e'(npc_sel)),
      .br_cond (br_cond),
      .imm16   (imm16),
      .imm26   (imm26),
      .rs_val  (rs_val),
      .target  (dec_target)
   );

   assign redirect_sel = exc_req | eret | pend_valid;

   always_comb begin
      npc = dec_target;
      if (exc_req)
         npc = EXC_VECTOR;
      else if (eret)
         npc = epc;
      else if (pend_valid)
         npc = pend_target;
   end

   // Any en=1 edge consumes the current npc, so the buffer only fills while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid  <= 1'b0;
         pend_kind   <= PEND_EXC;
         pend_target <= 32'd0;
      end else if (en) begin
         pend_valid <= 1'b0;
      end else if (exc_req) begin
         pend_valid  <= 1'b1;
         pend_kind   <= PEND_EXC;
         pend_target <= EXC_VECTOR;
      end else if (eret && (!pend_valid || pend_kind == PEND_ERET)) begin
         pend_valid  <= 1'b1;
         pend_kind   <= PEND_ERET;
         pend_target <= epc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         f_bd <= 1'b0;
      else if (en)
         f_bd <= (npc_sel != 2'd0) && !redirect_sel;
   end

   assign if_adel = (pc_f[1:0] != 2'b00) || (pc_f < IMEM_LO) || (pc_f > IMEM_HI);

   assign redirect_pending = pend_valid;

endmodule
